// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM: each access is a fixed-length
// transaction, with round-robin or fixed priority, locked bursts and a lock limit.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACC_CYC       = 2,
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MAX_LOCK      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_ram_cs,
    output logic              o_ram_oe,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
    localparam logic            WE_FIRST = (LAST_CYC == '0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cyc, w_cyc_nxt, w_cyc_inc;
    logic [CNT_W-1:0]    r_lock_cnt, w_lock_nxt;
    logic                r_last, w_last_nxt;     // 1: R1 was granted last
    logic                r_force, w_force_nxt;   // loser of a forced lock release wins the next tie
    logic                r_owner, w_owner_nxt;   // 1: R1 owns the transaction
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [1:0]          r_gnt, w_gnt_nxt;
    logic [1:0]          r_ack, w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0]   r_rdata1, w_rdata1_nxt;
    logic                r_ram_cs, w_ram_cs_nxt;
    logic                r_ram_oe, w_ram_oe_nxt;
    logic                r_ram_we, w_ram_we_nxt;
    logic                r_busy, w_busy_nxt;

    logic                w_pick1;
    logic                w_sel_we, w_own_we, w_own_req, w_own_lock, w_oth_req, w_lock_ok;
    logic [ADDR_W-1:0]   w_sel_addr, w_own_addr;
    logic [DATA_W-1:0]   w_sel_wdata, w_own_wdata;

    // Tie goes to the requester not granted last, unless fixed priority with no pending forced release.
    assign w_pick1 = (i_req0 && i_req1) ? (((PRIORITY_MODE == 0) || r_force) ? ~r_last : 1'b0)
                                        : i_req1;

    assign w_sel_we    = w_pick1 ? i_we1    : i_we0;
    assign w_sel_addr  = w_pick1 ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_pick1 ? i_wdata1 : i_wdata0;

    assign w_own_we    = r_owner ? i_we1    : i_we0;
    assign w_own_addr  = r_owner ? i_addr1  : i_addr0;
    assign w_own_wdata = r_owner ? i_wdata1 : i_wdata0;
    assign w_own_req   = r_owner ? i_req1   : i_req0;
    assign w_own_lock  = r_owner ? i_lock1  : i_lock0;
    assign w_oth_req   = r_owner ? i_req0   : i_req1;
    assign w_lock_ok   = w_own_lock && w_own_req && ((r_lock_cnt < LOCK_MAX) || !w_oth_req);
    assign w_cyc_inc   = r_cyc + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_lock_nxt   = r_lock_cnt;
        w_last_nxt   = r_last;
        w_force_nxt  = r_force;
        w_owner_nxt  = r_owner;
        w_we_nxt     = r_we;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = 2'b00;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_ram_cs_nxt = 1'b0;
        w_ram_oe_nxt = 1'b0;
        w_ram_we_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_state_nxt  = ST_ACCESS;
                    w_cyc_nxt    = '0;
                    w_owner_nxt  = w_pick1;
                    w_we_nxt     = w_sel_we;
                    w_addr_nxt   = w_sel_addr;
                    w_wdata_nxt  = w_sel_wdata;
                    w_gnt_nxt    = w_pick1 ? 2'b10 : 2'b01;
                    w_force_nxt  = 1'b0;
                    w_ram_cs_nxt = 1'b1;
                    w_ram_oe_nxt = !w_sel_we;
                    w_ram_we_nxt = w_sel_we && WE_FIRST;
                end
            end
            ST_ACCESS: begin
                if (r_cyc == LAST_CYC) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = r_owner ? 2'b10 : 2'b01;
                    if (!r_we) begin
                        if (r_owner) w_rdata1_nxt = i_ram_rdata;
                        else         w_rdata0_nxt = i_ram_rdata;
                    end
                end else begin
                    w_cyc_nxt    = w_cyc_inc;
                    w_ram_cs_nxt = 1'b1;
                    w_ram_oe_nxt = !r_we;
                    w_ram_we_nxt = r_we && (w_cyc_inc == LAST_CYC);
                end
            end
            ST_DONE: begin
                if (w_lock_ok) begin
                    w_state_nxt  = ST_ACCESS;
                    w_cyc_nxt    = '0;
                    w_we_nxt     = w_own_we;
                    w_addr_nxt   = w_own_addr;
                    w_wdata_nxt  = w_own_wdata;
                    w_ram_cs_nxt = 1'b1;
                    w_ram_oe_nxt = !w_own_we;
                    w_ram_we_nxt = w_own_we && WE_FIRST;
                    if (r_lock_cnt < LOCK_MAX) w_lock_nxt = r_lock_cnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 2'b00;
                    w_lock_nxt  = '0;
                    w_last_nxt  = r_owner;
                    w_force_nxt = w_own_lock && w_own_req;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_lock_cnt <= '0;
            r_last     <= 1'b1;
            r_force    <= 1'b0;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_gnt      <= 2'b00;
            r_ack      <= 2'b00;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_ram_cs   <= 1'b0;
            r_ram_oe   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_last     <= w_last_nxt;
            r_force    <= w_force_nxt;
            r_owner    <= w_owner_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_rdata0   <= w_rdata0_nxt;
            r_rdata1   <= w_rdata1_nxt;
            r_ram_cs   <= w_ram_cs_nxt;
            r_ram_oe   <= w_ram_oe_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign o_gnt0      = r_gnt[0];
    assign o_gnt1      = r_gnt[1];
    assign o_ack0      = r_ack[0];
    assign o_ack1      = r_ack[1];
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_ram_cs    = r_ram_cs;
    assign o_ram_oe    = r_ram_oe;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance a is round-robin, instance b fixed R0 priority;
// both share requester inputs and each drives its own 32x8 RAM model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;

    logic          a_gnt0, a_gnt1, a_ack0, a_ack1, a_cs, a_oe, a_we, a_busy;
    logic [DW-1:0] a_rd0, a_rd1, a_wdata, a_rdata;
    logic [AW-1:0] a_addr;
    logic          b_gnt0, b_gnt1, b_ack0, b_ack1, b_cs, b_oe, b_we, b_busy;
    logic [DW-1:0] b_rd0, b_rd1, b_wdata, b_rdata;
    logic [AW-1:0] b_addr;

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];

    int n_pass = 0, n_fail = 0, n_total = 0, excl_viol = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (a_cs && a_we) mem_a[a_addr] <= a_wdata;
    always @(posedge clk) if (b_cs && b_we) mem_b[b_addr] <= b_wdata;
    assign a_rdata = mem_a[a_addr];
    assign b_rdata = mem_b[b_addr];

    always @(negedge clk) if ((a_gnt0 && a_gnt1) || (b_gnt0 && b_gnt1)) excl_viol++;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(2), .PRIORITY_MODE(0), .MAX_LOCK(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
        .i_we0(we0), .i_we1(we1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(a_gnt0), .o_gnt1(a_gnt1), .o_ack0(a_ack0), .o_ack1(a_ack1),
        .o_rdata0(a_rd0), .o_rdata1(a_rd1),
        .o_ram_cs(a_cs), .o_ram_oe(a_oe), .o_ram_we(a_we),
        .o_ram_addr(a_addr), .o_ram_wdata(a_wdata), .i_ram_rdata(a_rdata),
        .o_busy(a_busy)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(2), .PRIORITY_MODE(1), .MAX_LOCK(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
        .i_we0(we0), .i_we1(we1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_ack0(b_ack0), .o_ack1(b_ack1),
        .o_rdata0(b_rd0), .o_rdata1(b_rd1),
        .o_ram_cs(b_cs), .o_ram_oe(b_oe), .o_ram_we(b_we),
        .o_ram_addr(b_addr), .o_ram_wdata(b_wdata), .i_ram_rdata(b_rdata),
        .o_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits a bounded number of clocks for an ACK on instance a.
    task automatic wait_ack(input bit which, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = which ? a_ack1 : a_ack0;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_seq[6];
        int b_seq[6];
        int ev[8];
        int t_ack[12];
        int na, nb, ne, n1, gap, nt;
        bit pa0, pa1, pb0, pb1, started;

        // Reset state
        repeat (2) tick();
        chk("reset_ctrl", 32'({a_gnt0, a_gnt1, a_ack0, a_ack1, a_cs, a_oe, a_we, a_busy,
                               b_gnt0, b_gnt1, b_ack0, b_ack1, b_cs, b_oe, b_we, b_busy}), 32'd0);
        chk("reset_data", 32'({a_rd0, a_rd1, a_addr}), 32'd0);
        chk("reset_data_b", 32'({b_rd0, b_rd1}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write then read-back by R0
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h05; wdata0 = 8'hA5;
        tick();
        chk("wr_grant", 32'({a_gnt0, a_gnt1, a_cs, a_we, a_busy}), 32'b10101);
        addr0 = 5'h1F; wdata0 = 8'h00;
        tick();
        chk("wr_strobe", 32'({a_cs, a_we, a_oe, a_ack0}), 32'b1100);
        chk("wr_addr_data", 32'({a_addr, a_wdata}), 32'({5'h05, 8'hA5}));
        tick();
        chk("wr_ack", 32'({a_ack0, a_gnt0, a_cs, a_we, a_busy}), 32'b11001);
        req0 = 1'b0; we0 = 1'b0; addr0 = 5'h05;
        tick();
        chk("wr_idle", 32'({a_ack0, a_gnt0, a_busy}), 32'd0);
        req0 = 1'b1;
        tick();
        chk("rd_grant", 32'({a_gnt0, a_cs, a_oe, a_we}), 32'b1110);
        tick();
        tick();
        chk("rd_ack_data", 32'({a_ack0, a_rd0}), 32'({1'b1, 8'hA5}));
        req0 = 1'b0;
        tick();

        // Both requesting: a alternates, b favours R0 until REQ0 drops
        do_reset();
        for (int k = 0; k < 6; k++) begin a_seq[k] = 7; b_seq[k] = 7; end
        na = 0; nb = 0; pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (a_gnt0 && !pa0 && na < 6) begin a_seq[na] = 0; na++; end
            if (a_gnt1 && !pa1 && na < 6) begin a_seq[na] = 1; na++; end
            if (b_gnt0 && !pb0 && nb < 6) begin b_seq[nb] = 0; nb++; end
            if (b_gnt1 && !pb1 && nb < 6) begin b_seq[nb] = 1; nb++; end
            pa0 = a_gnt0; pa1 = a_gnt1; pb0 = b_gnt0; pb1 = b_gnt1;
            if (nb == 4 && b_ack0) req0 = 1'b0;
        end
        for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 32'(a_seq[k]), 32'(k % 2));
        for (int k = 0; k < 5; k++) chk($sformatf("fixed_grant%0d", k), 32'(b_seq[k]), 32'(k == 4));
        req0 = 1'b0; req1 = 1'b0;

        // R1 locked burst, R0 arrives after the first access
        do_reset();
        for (int k = 0; k < 8; k++) ev[k] = 7;
        ne = 0; n1 = 0; gap = 0;
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 5'h03; wdata1 = 8'h33;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (n1 >= 1 && n1 < 5 && !a_gnt1) gap++;
            if (a_ack1 && ne < 8) begin ev[ne] = 1; ne++; n1++; end
            if (a_ack0 && ne < 8) begin ev[ne] = 0; ne++; req0 = 1'b0; end
            if (n1 == 1 && a_ack1) req0 = 1'b1;
            if (n1 == 6 && a_ack1) begin req1 = 1'b0; lock1 = 1'b0; end
        end
        for (int k = 0; k < 7; k++) chk($sformatf("lock_order%0d", k), 32'(ev[k]), 32'(k != 5));
        chk("lock_gnt_held", 32'(gap), 32'd0);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;

        // R0 locked with R1 idle: ten back-to-back reads
        do_reset();
        nt = 0; gap = 0; started = 0;
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 5'h05;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (a_gnt0) started = 1;
            if (started && nt < 10 && !(a_gnt0 && a_busy)) gap++;
            if (a_ack0 && nt < 12) begin t_ack[nt] = c; nt++; end
            if (nt == 10 && a_ack0) begin req0 = 1'b0; lock0 = 1'b0; end
        end
        chk("burst_count", 32'(nt), 32'd10);
        chk("burst_no_gap", 32'(gap), 32'd0);
        for (int k = 1; k < 10; k++) chk($sformatf("burst_spacing%0d", k), 32'(t_ack[k] - t_ack[k-1]), 32'd3);
        chk("burst_rdata", 32'(a_rd0), 32'hA5);

        // Reset in the middle of a write aborts it; R0 wins the tie afterwards
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h07; wdata0 = 8'h11;
        wait_ack(1'b0, "pre_wr_ack");
        req0 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h07; wdata0 = 8'h3C;
        tick();
        tick();
        chk("abort_in_write", 32'({a_cs, a_we}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({a_gnt0, a_gnt1, a_ack0, a_ack1, a_cs, a_oe, a_we, a_busy}), 32'd0);
        we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 5'h07;
        tick();
        tick();
        chk("abort_no_ack", 32'({a_ack0, a_ack1}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_tie_r0", 32'({a_gnt0, a_gnt1}), 32'b10);
        wait_ack(1'b0, "abort_rd_ack");
        chk("abort_mem_kept", 32'(a_rd0), 32'h11);
        req0 = 1'b0;
        wait_ack(1'b1, "after_r1_ack");
        chk("after_r1_rdata", 32'(a_rd1), 32'h11);
        req1 = 1'b0;
        tick();

        // R1 drops REQ during a read: ACK and RDATA1 still arrive; writes leave RDATA1 alone
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h09; wdata1 = 8'h5A;
        wait_ack(1'b1, "drop_wr_ack");
        chk("drop_wr_keeps_rdata", 32'(a_rd1), 32'h11);
        req1 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0;
        tick();
        chk("drop_grant", 32'({a_gnt0, a_gnt1}), 32'b01);
        req1 = 1'b0;
        wait_ack(1'b1, "drop_rd_ack");
        chk("drop_rdata1", 32'(a_rd1), 32'h5A);
        chk("drop_rdata0_kept", 32'(a_rd0), 32'h11);
        tick();
        chk("drop_idle", 32'({a_gnt1, a_busy}), 32'd0);

        chk("gnt_exclusive", 32'(excl_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
